counter_ctrl: RTL and testbench

- Run controller for the board-level display counter. Sequences start, pause, clear, load and up/down stepping of a CNT_W-bit count.
- A clock-enable tick from an internal prescaler paces the count. All logic is on the single clk domain; no derived clocks.
- Sits between the debounced push-button/switch decode and the LED/seven-segment output.

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter_ctrl_tick_gen.sv | 31 +++
 rtl/counter_ctrl.sv | 116 +++++++++++
 tb/tb_counter_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the display counter run controller.
package counter_ctrl_pkg;

   // DONE keeps its encoding even when the one-shot feature is compiled out
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_DIV   = 2097152;
   localparam int unsigned DEF_PRE_W = 26;
   localparam int unsigned DEF_CNT_W = 4;

   // Command priority indices: lower index wins within one cycle
   localparam int unsigned PRI_CLEAR = 0;
   localparam int unsigned PRI_LOAD  = 1;
   localparam int unsigned PRI_STOP  = 2;
   localparam int unsigned PRI_START = 3;
   localparam int unsigned N_CMD     = 4;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler producing a one-cycle step enable every DIV enabled cycles.
module tick_gen #(
   parameter int unsigned DIV   = 2097152,
   parameter int unsigned PRE_W = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre;

   assign tick = en && (pre == PRE_LAST);

   // Holds its value whenever en is low, so a pause resumes mid-period
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (sync_clr) begin
         pre <= '0;
      end else if (en) begin
         if (tick) pre <= '0;
         else      pre <= pre + PRE_W'(1);
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for the display counter: start/pause/clear/load and up/down stepping.
// Optional one-shot stop at terminal value when COUNTER_CTRL_ONESHOT_EN is defined.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned DIV   = DEF_DIV,
   parameter int unsigned PRE_W = DEF_PRE_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_start,
   input  logic             cmd_stop,
   input  logic             cmd_clear,
   input  logic             cmd_load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dir_up,
`ifdef COUNTER_CTRL_ONESHOT_EN
   input  logic             oneshot,
`endif
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             running,
   output logic             tc
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [N_CMD-1:0] cmd;
   logic             run_en;
   logic             pre_clr;
   logic             wraps;
   logic             os_hit;

   always_comb begin
      cmd            = '0;
      cmd[PRI_CLEAR] = cmd_clear;
      cmd[PRI_LOAD]  = cmd_load;
      cmd[PRI_STOP]  = cmd_stop;
      cmd[PRI_START] = cmd_start;
   end

   // Any higher-priority command this cycle suppresses both the prescaler and the step
   assign run_en  = (state == RUN) && !cmd[PRI_CLEAR] && !cmd[PRI_LOAD] && !cmd[PRI_STOP];
   assign pre_clr = cmd[PRI_CLEAR] || cmd[PRI_LOAD];

   tick_gen #(
      .DIV   (DIV),
      .PRE_W (PRE_W)
   ) u_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (run_en),
      .sync_clr (pre_clr),
      .tick     (tick)
   );

   assign wraps = dir_up ? (count == CNT_MAX) : (count == '0);

`ifdef COUNTER_CTRL_ONESHOT_EN
   assign os_hit = oneshot && wraps;
`else
   assign os_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         running <= 1'b0;
         tc      <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (cmd[PRI_CLEAR]) begin
            state   <= IDLE;
            count   <= '0;
            running <= 1'b0;
         end else if (cmd[PRI_LOAD]) begin
            count <= load_val;
            if (state == DONE) begin
               state   <= IDLE;
               running <= 1'b0;
            end
         end else if (tick) begin
            tc <= wraps;
            // One-shot parks on the terminal value, which the count already holds
            if (os_hit) begin
               state   <= DONE;
               running <= 1'b0;
            end else if (dir_up) begin
               count <= count + CNT_W'(1);
            end else begin
               count <= count - CNT_W'(1);
            end
         end else begin
            case (state)
               IDLE, PAUSE: begin
                  if (cmd[PRI_START]) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (cmd[PRI_STOP]) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl with DIV=4, CNT_W=4.
module tb_counter_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_start, cmd_stop, cmd_clear, cmd_load;
   logic [CNT_W-1:0] load_val;
   logic             dir_up;
`ifdef COUNTER_CTRL_ONESHOT_EN
   logic             oneshot;
`endif
   logic [CNT_W-1:0] count;
   logic             tick, running, tc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.CNT_W(CNT_W), .DIV(4), .PRE_W(26)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_start (cmd_start),
      .cmd_stop  (cmd_stop),
      .cmd_clear (cmd_clear),
      .cmd_load  (cmd_load),
      .load_val  (load_val),
      .dir_up    (dir_up),
`ifdef COUNTER_CTRL_ONESHOT_EN
      .oneshot   (oneshot),
`endif
      .count     (count),
      .tick      (tick),
      .running   (running),
      .tc        (tc)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_start = 0; cmd_stop = 0; cmd_clear = 0; cmd_load = 0;
      load_val = '0; dir_up = 1'b1;
`ifdef COUNTER_CTRL_ONESHOT_EN
      oneshot = 1'b0;
`endif
      cyc(2);
      rst = 1'b0;
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got=%b exp=0", running); end
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b exp=0", tc); end
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick); end
      cyc(3);
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL idle_hold_count got=%0d exp=0", count); end
   endtask

   task automatic test_run_basic();
      cmd_stop = 1'b1;
      cyc(2);
      cmd_stop = 1'b0;
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL stop_in_idle got=%b exp=0", running); end
      cmd_start = 1'b1;
      cyc(1);
      cmd_start = 1'b0;
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_running got=%b exp=1", running); end
      for (int i = 1; i <= 4; i++) begin
         n_cmp++; if (tick !== (i == 4)) begin n_err++; $display("FAIL run_tick_c%0d got=%b exp=%b", i, tick, (i == 4)); end
         n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL run_count_c%0d got=%0d exp=0", i, count); end
         if (i < 4) cyc(1);
      end
      cyc(1);
      n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL run_step1 got=%0d exp=1", count); end
      cyc(3);
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL run_tick2 got=%b exp=1", tick); end
      cyc(1);
      n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL run_step2 got=%0d exp=2", count); end
   endtask

   task automatic test_wrap();
      cmd_load = 1'b1; load_val = 4'd14;
      cyc(1);
      cmd_load = 1'b0;
      n_cmp++; if (count !== 4'd14) begin n_err++; $display("FAIL wrap_load got=%0d exp=14", count); end
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL wrap_load_run got=%b exp=1", running); end
      cyc(4);
      n_cmp++; if (count !== 4'd15 || tc !== 1'b0) begin n_err++; $display("FAIL wrap_15 got=%0d/%b exp=15/0", count, tc); end
      cyc(4);
      n_cmp++; if (count !== 4'd0 || tc !== 1'b1) begin n_err++; $display("FAIL wrap_up got=%0d/%b exp=0/1", count, tc); end
      cyc(1);
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL wrap_tc_pulse got=%b exp=0", tc); end
      dir_up = 1'b0;
      cyc(3);
      n_cmp++; if (count !== 4'd15 || tc !== 1'b1) begin n_err++; $display("FAIL wrap_down got=%0d/%b exp=15/1", count, tc); end
      cyc(1);
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL wrap_down_pulse got=%b exp=0", tc); end
      dir_up = 1'b1;
   endtask

   task automatic test_pause();
      cyc(1);
      cmd_stop = 1'b1;
      cyc(1);
      n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL pause_running got=%b exp=0", running); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (tick !== 1'b0 || count !== 4'd15) begin n_err++; $display("FAIL pause_hold_%0d got=%b/%0d exp=0/15", i, tick, count); end
         cyc(1);
      end
      cmd_stop = 1'b0; cmd_start = 1'b1;
      cyc(1);
      cmd_start = 1'b0;
      n_cmp++; if (running !== 1'b1 || tick !== 1'b0) begin n_err++; $display("FAIL resume got=%b/%b exp=1/0", running, tick); end
      cyc(1);
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL resume_tick got=%b exp=1", tick); end
      cyc(1);
      n_cmp++; if (count !== 4'd0 || tc !== 1'b1) begin n_err++; $display("FAIL resume_step got=%0d/%b exp=0/1", count, tc); end
   endtask

   task automatic test_load_tick();
      cyc(3);
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL lt_pre_tick got=%b exp=1", tick); end
      cmd_load = 1'b1; load_val = 4'd9;
      #1;
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL lt_tick_masked got=%b exp=0", tick); end
      cyc(1);
      cmd_load = 1'b0;
      n_cmp++; if (count !== 4'd9 || tc !== 1'b0) begin n_err++; $display("FAIL lt_load got=%0d/%b exp=9/0", count, tc); end
      cyc(3);
      n_cmp++; if (tick !== 1'b1 || count !== 4'd9) begin n_err++; $display("FAIL lt_next_tick got=%b/%0d exp=1/9", tick, count); end
      cyc(1);
      n_cmp++; if (count !== 4'd10) begin n_err++; $display("FAIL lt_next_step got=%0d exp=10", count); end
      cmd_load = 1'b1; load_val = 4'd3;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         n_cmp++; if (tick !== 1'b1 && tick !== 1'b0) begin n_err++; $display("FAIL lt_x got=%b", tick); end
         n_cmp++; if (tick !== 1'b0 || count !== 4'd3) begin n_err++; $display("FAIL lt_held_%0d got=%b/%0d exp=0/3", i, tick, count); end
      end
      cmd_load = 1'b0;
      cyc(3);
      n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL lt_release_tick got=%b exp=1", tick); end
      cyc(1);
      n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL lt_release_step got=%0d exp=4", count); end
   endtask

   task automatic test_clear_combo();
      cmd_clear = 1'b1; cmd_load = 1'b1; load_val = 4'd5; cmd_start = 1'b1;
      cyc(1);
      cmd_clear = 1'b0; cmd_load = 1'b0; cmd_start = 1'b0;
      n_cmp++; if (count !== 4'd0 || running !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL clr_combo got=%0d/%b/%b exp=0/0/0", count, running, tick); end
      cyc(5);
      n_cmp++; if (count !== 4'd0 || running !== 1'b0) begin n_err++; $display("FAIL clr_idle got=%0d/%b exp=0/0", count, running); end
      cmd_start = 1'b1;
      cyc(5);
      n_cmp++; if (count !== 4'd1 || running !== 1'b1) begin n_err++; $display("FAIL held_start got=%0d/%b exp=1/1", count, running); end
      cmd_start = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      n_cmp++; if (count !== 4'd0 || running !== 1'b0 || tc !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL mid_rst got=%0d/%b/%b/%b exp=0/0/0/0", count, running, tc, tick); end
      rst = 1'b0;
      cyc(6);
      n_cmp++; if (running !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL post_rst_idle got=%b/%0d exp=0/0", running, count); end
   endtask

`ifdef COUNTER_CTRL_ONESHOT_EN
   task automatic test_oneshot();
      oneshot = 1'b1; dir_up = 1'b1;
      cmd_load = 1'b1; load_val = 4'd13;
      cyc(1);
      cmd_load = 1'b0; cmd_start = 1'b1;
      cyc(1);
      cmd_start = 1'b0;
      cyc(4);
      n_cmp++; if (count !== 4'd14) begin n_err++; $display("FAIL os_14 got=%0d exp=14", count); end
      cyc(4);
      n_cmp++; if (count !== 4'd15 || tc !== 1'b0) begin n_err++; $display("FAIL os_15 got=%0d/%b exp=15/0", count, tc); end
      cyc(4);
      n_cmp++; if (count !== 4'd15 || tc !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL os_done got=%0d/%b/%b exp=15/1/0", count, tc, running); end
      cmd_start = 1'b1;
      cyc(6);
      cmd_start = 1'b0;
      n_cmp++; if (count !== 4'd15 || tc !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL os_start_ign got=%0d/%b/%b exp=15/0/0", count, tc, running); end
      cmd_clear = 1'b1;
      cyc(1);
      cmd_clear = 1'b0;
      n_cmp++; if (count !== 4'd0 || running !== 1'b0) begin n_err++; $display("FAIL os_clear got=%0d/%b exp=0/0", count, running); end
      cmd_start = 1'b1;
      cyc(1);
      cmd_start = 1'b0;
      n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL os_restart got=%b exp=1", running); end
      oneshot = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_run_basic();
      test_wrap();
      test_pause();
      test_load_tick();
      test_clear_combo();
`ifdef COUNTER_CTRL_ONESHOT_EN
      test_oneshot();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
